// File: rtl/iris_pkg.sv
// Shared definitions for the circular iris screen-transition controller.
// Holds the FSM state encoding and the RGB AND-mask constants used by
// iris_transition_ctrl and iris_mask_pipe.
package iris_pkg;

    // FSM states kept as plain 2-bit constants so older blocks can reuse them
    typedef logic [1:0] iris_state_t;

    localparam iris_state_t OPEN    = 2'd0;
    localparam iris_state_t CLOSING = 2'd1;
    localparam iris_state_t DARK    = 2'd2;
    localparam iris_state_t OPENING = 2'd3;

    // RGB AND-masks: fully lit, fully dark, and the half-bright soft edge
    localparam logic [11:0] MASK_ON   = 12'hFFF;
    localparam logic [11:0] MASK_OFF  = 12'h000;
    localparam logic [11:0] MASK_HALF = 12'h777;

endpackage

// File: rtl/iris_mask_pipe.sv
// Two-stage distance/compare pipeline that turns a pixel address into an
// RGB AND-mask for the iris. Stage 1 registers the absolute offsets from the
// iris centre together with the radius and the "fully open" flag; stage 2
// registers the mask itself, so the mask trails the address by two clocks.
// Optional feature: define IRIS_SOFT_EDGE_EN to add a half-bright ring of
// EDGE_W pixels just outside the circle (adds one more squarer).
module iris_mask_pipe
    import iris_pkg::*;
#(
    parameter int RW = 10
`ifdef IRIS_SOFT_EDGE_EN
    , parameter int EDGE_W = 4
`endif
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [9:0]    cx,
    input  logic [8:0]    cy,
    input  logic [9:0]    col_addr,
    input  logic [8:0]    row_addr,
    input  logic [RW-1:0] radius,
    input  logic          open_flag,
    output logic [11:0]   mask
);

    // Wide enough for dx^2+dy^2 (21 bits) and for the squared radius plus ring
    localparam int CW = (2 * RW + 4 > 22) ? 2 * RW + 4 : 22;

    logic [9:0]    dx_d;
    logic [8:0]    dy_d;
    logic [9:0]    dx_q;
    logic [8:0]    dy_q;
    logic [RW-1:0] r_q;
    logic          open_q;
    logic [CW-1:0] dist2;
    logic [CW-1:0] r2;
    logic [11:0]   mask_d;
`ifdef IRIS_SOFT_EDGE_EN
    logic [CW-1:0] r_outer;
    logic [CW-1:0] r_outer2;
`endif

    // Unsigned absolute offsets from the centre; subtract the smaller from the larger so nothing wraps
    always_comb begin
        dx_d = (col_addr >= cx) ? (col_addr - cx) : (cx - col_addr);
        dy_d = (row_addr >= cy) ? (row_addr - cy) : (cy - row_addr);
    end

    // Stage 1: capture offsets, the radius of this cycle and whether the iris is fully open
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dx_q   <= '0;
            dy_q   <= '0;
            r_q    <= '0;
            open_q <= 1'b0;
        end else begin
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            r_q    <= radius;
            open_q <= open_flag;
        end
    end

    // Squared distance against squared radius; equality counts as inside so radius 0 lights the centre pixel
    always_comb begin
        dist2 = CW'(dx_q) * CW'(dx_q) + CW'(dy_q) * CW'(dy_q);
        r2    = CW'(r_q) * CW'(r_q);
`ifdef IRIS_SOFT_EDGE_EN
        r_outer  = CW'(r_q) + CW'(EDGE_W);
        r_outer2 = r_outer * r_outer;
`endif
        mask_d = MASK_OFF;
        if (open_q || (dist2 <= r2)) begin
            mask_d = MASK_ON;
`ifdef IRIS_SOFT_EDGE_EN
        end else if ((r_q != '0) && (dist2 <= r_outer2)) begin
            mask_d = MASK_HALF;
`endif
        end
    end

    // Stage 2: registered mask output
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask <= MASK_OFF;
        end else begin
            mask <= mask_d;
        end
    end

endmodule

// File: rtl/iris_transition_ctrl.sv
// Circular iris screen-transition controller sitting between the game logic
// and the VGA pixel path. It shrinks a circle around (cx,cy) to black, holds
// the screen dark while pulsing the game reset, then reopens the circle.
// A close request while reopening reverses the iris from its current radius.
// The per-pixel mask is produced by iris_mask_pipe with a two-clock latency.
// Optional feature: define IRIS_SOFT_EDGE_EN for a half-bright EDGE_W ring.
module iris_transition_ctrl
    import iris_pkg::*;
#(
    parameter int  MAX_RADIUS  = 640,
    parameter int  STEP        = 1,
    parameter int  HOLD_FRAMES = 30,
    parameter int  RST_CYCLES  = 8,
    parameter int  EDGE_W      = 4,
    localparam int RW          = $clog2(MAX_RADIUS + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          frame_tick,
    input  logic          trig_close,
    input  logic [9:0]    cx,
    input  logic [8:0]    cy,
    input  logic [9:0]    col_addr,
    input  logic [8:0]    row_addr,
    output logic [11:0]   mask,
    output logic          game_rstn,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] radius
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int CW = $clog2(RST_CYCLES + 1);

    localparam logic [RW-1:0] STEP_R    = RW'(STEP);
    localparam logic [RW-1:0] MAX_R     = RW'(MAX_RADIUS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);

    // Reject parameter sets the FSM cannot honour
    if ((STEP < 1) || (STEP > MAX_RADIUS)) begin : g_bad_step
        $error("iris_transition_ctrl: STEP must be within 1..MAX_RADIUS");
    end
    if (HOLD_FRAMES < 1) begin : g_bad_hold
        $error("iris_transition_ctrl: HOLD_FRAMES must be at least 1");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("iris_transition_ctrl: RST_CYCLES must be at least 1");
    end
    if (EDGE_W < 1) begin : g_bad_edge
        $error("iris_transition_ctrl: EDGE_W must be at least 1");
    end

    iris_state_t   state;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] rst_cnt;
    logic [RW:0]   radius_up;
    logic          enter_dark;
    logic          is_open;

    // One extra bit on the growing radius so the clamp to MAX_RADIUS never sees a wrap
    always_comb begin
        radius_up  = {1'b0, radius} + {1'b0, STEP_R};
        enter_dark = (state == CLOSING) && frame_tick && (radius <= STEP_R);
        is_open    = (state == OPEN);
    end

    assign busy = !is_open;

    // Iris FSM: radius only moves on frame ticks, a close request while opening beats a coincident tick
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= DARK;
            radius   <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                OPEN: begin
                    if (trig_close) begin
                        state <= CLOSING;
                    end
                end
                CLOSING: begin
                    if (frame_tick) begin
                        if (radius <= STEP_R) begin
                            radius   <= '0;
                            hold_cnt <= '0;
                            state    <= DARK;
                        end else begin
                            radius <= radius - STEP_R;
                        end
                    end
                end
                DARK: begin
                    if (frame_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= OPENING;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                OPENING: begin
                    if (trig_close) begin
                        state <= CLOSING;
                    end else if (frame_tick) begin
                        if (radius_up >= {1'b0, MAX_R}) begin
                            radius <= MAX_R;
                            state  <= OPEN;
                            done   <= 1'b1;
                        end else begin
                            radius <= radius_up[RW-1:0];
                        end
                    end
                end
                default: begin
                    state <= DARK;
                end
            endcase
        end
    end

    // Game reset pulse: low for RST_CYCLES clocks from reset or from each entry into DARK
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_cnt   <= '0;
            game_rstn <= 1'b0;
        end else if (enter_dark) begin
            rst_cnt   <= '0;
            game_rstn <= 1'b0;
        end else if (!game_rstn) begin
            if (rst_cnt == RST_LAST) begin
                game_rstn <= 1'b1;
            end else begin
                rst_cnt <= rst_cnt + CW'(1);
            end
        end
    end

    iris_mask_pipe #(
        .RW(RW)
`ifdef IRIS_SOFT_EDGE_EN
        , .EDGE_W(EDGE_W)
`endif
    ) u_mask_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .cx        (cx),
        .cy        (cy),
        .col_addr  (col_addr),
        .row_addr  (row_addr),
        .radius    (radius),
        .open_flag (is_open),
        .mask      (mask)
    );

endmodule
